// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers (polynomial 0x11B).
// Pure definitions: no latency and no flow control of their own.
package aes_pkg;
   localparam int NUM_COLS  = 4;
   localparam int NUM_ROWS  = 4;
   localparam int BYTE_W    = 8;
   localparam int COL_W     = NUM_ROWS * BYTE_W;
   localparam int STATE_W   = NUM_COLS * COL_W;
   localparam int COL_IDX_W = 2;
   localparam int ROW_IDX_W = 2;

   localparam logic [BYTE_W-1:0] GF_RED = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } inv_mc_state_e;

   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
      return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_RED : 8'h00);
   endfunction

   function automatic logic [BYTE_W-1:0] gmul9(input logic [BYTE_W-1:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [BYTE_W-1:0] gmul11(input logic [BYTE_W-1:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [BYTE_W-1:0] gmul13(input logic [BYTE_W-1:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [BYTE_W-1:0] gmul14(input logic [BYTE_W-1:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction
endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns on one 32-bit column (byte 0 in the MSBs).
// Zero latency; no handshake, the caller owns flow control.
module inv_mix_single_column
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] i_col,
   output logic [COL_W-1:0] o_col
);
   logic [BYTE_W-1:0] w_a [NUM_ROWS];
   logic [BYTE_W-1:0] w_b [NUM_ROWS];

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign w_a[r] = i_col[COL_W-1-BYTE_W*r -: BYTE_W];
      assign w_b[r] = gmul14(w_a[r])
                    ^ gmul11(w_a[(r+1) % NUM_ROWS])
                    ^ gmul13(w_a[(r+2) % NUM_ROWS])
                    ^ gmul9 (w_a[(r+3) % NUM_ROWS]);
      assign o_col[COL_W-1-BYTE_W*r -: BYTE_W] = w_b[r];
   end
endmodule

// File: rtl/inv_mixcolumn_seq.sv
// Iterative InvMixColumns: COLS_PER_CYCLE columns per BUSY cycle, result valid 4/COLS_PER_CYCLE edges after accept.
// Accepts only in IDLE; holds the result in DONE until ready_i, so the output is stable under backpressure.
module inv_mixcolumn_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [STATE_W-1:0] inv_mixcolumn_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic [STATE_W-1:0] inv_mixcolumn_o,
   output logic               valid_o,
   input  logic               ready_i
);
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("inv_mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // A step of 4 truncates to 0; harmless because that configuration leaves BUSY after one cycle.
   localparam logic [COL_IDX_W-1:0] CNT_STEP = COL_IDX_W'(COLS_PER_CYCLE);
   localparam logic [COL_IDX_W-1:0] CNT_LAST = COL_IDX_W'(NUM_COLS - COLS_PER_CYCLE);

   inv_mc_state_e                    r_state;
   inv_mc_state_e                    w_state_nxt;
   logic [NUM_COLS-1:0][COL_W-1:0]   r_work;
   logic [COL_IDX_W-1:0]             r_cnt;

   logic [COL_IDX_W-1:0] w_slot    [COLS_PER_CYCLE];
   logic [COL_W-1:0]     w_col_in  [COLS_PER_CYCLE];
   logic [COL_W-1:0]     w_col_out [COLS_PER_CYCLE];

   // Column c lives in packed slot NUM_COLS-1-c so that column 0 sits in the MSBs.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_core
      assign w_slot[g]   = COL_IDX_W'(NUM_COLS - 1) - (r_cnt + COL_IDX_W'(g));
      assign w_col_in[g] = r_work[w_slot[g]];

      inv_mix_single_column u_core (
         .i_col (w_col_in[g]),
         .o_col (w_col_out[g])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      ready_o         = 1'b0;
      valid_o         = 1'b0;
      inv_mixcolumn_o = '0;
      case (r_state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            valid_o         = 1'b1;
            inv_mixcolumn_o = r_work;
            if (ready_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_work <= '0;
         r_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (valid_i) begin
                  r_work <= inv_mixcolumn_i;
                  r_cnt  <= '0;
               end
            end
            ST_BUSY: begin
               for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                  r_work[w_slot[g]] <= w_col_out[g];
               end
               r_cnt <= r_cnt + CNT_STEP;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Directed and round-trip bench for inv_mixcolumn_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_inv_mixcolumn_seq;
   localparam int NI = 3;

   localparam logic [127:0] V1_IN   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V1_OUT  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] FIPS_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] din  [NI];
   logic         vin  [NI];
   logic         rdy  [NI];
   logic [127:0] dout [NI];
   logic         vout [NI];
   logic         rin  [NI];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   inv_mixcolumn_seq #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk_i(clk), .rst_i(rst), .inv_mixcolumn_i(din[0]), .valid_i(vin[0]), .ready_o(rdy[0]),
      .inv_mixcolumn_o(dout[0]), .valid_o(vout[0]), .ready_i(rin[0]));
   inv_mixcolumn_seq #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk_i(clk), .rst_i(rst), .inv_mixcolumn_i(din[1]), .valid_i(vin[1]), .ready_o(rdy[1]),
      .inv_mixcolumn_o(dout[1]), .valid_o(vout[1]), .ready_i(rin[1]));
   inv_mixcolumn_seq #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk_i(clk), .rst_i(rst), .inv_mixcolumn_i(din[2]), .valid_i(vin[2]), .ready_o(rdy[2]),
      .inv_mixcolumn_o(dout[2]), .valid_o(vout[2]), .ready_i(rin[2]));

   function automatic int ncyc(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 1;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Forward MixColumns, used to build round-trip stimulus.
   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0]  a [4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      for (int i = 0; i < 4; i++)
         r[31-8*i -: 8] = xt(a[i]) ^ xt(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      return r;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      return {mixcol(s[127:96]), mixcol(s[95:64]), mixcol(s[63:32]), mixcol(s[31:0])};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      for (int k = 0; k < NI; k++) begin
         vin[k] = 1'b0;
         rin[k] = 1'b1;
         din[k] = '0;
      end
      rst = 1'b1;
      repeat (2) tick();
      #3 rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #2;
      for (int k = 0; k < NI; k++) begin
         total++; if (rdy[k] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy[k]); end
         total++; if (vout[k] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", k, vout[k]); end
         total++; if (dout[k] !== 128'h0) begin bad++; $display("FAIL reset_data[%0d]: got %h want 0", k, dout[k]); end
      end
   endtask

   // valid_o must appear after exactly N edges past the accepting edge, for one cycle.
   task automatic test_single();
      logic exp_v, exp_r;
      do_reset();
      total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL single_ready_pre: got %b want 1", rdy[0]); end
      din[0] = V1_IN; vin[0] = 1'b1;
      tick();
      vin[0] = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         exp_v = (e == 4);
         exp_r = (e >= 5);
         total++; if (vout[0] !== exp_v) begin bad++; $display("FAIL single_valid e=%0d: got %b want %b", e, vout[0], exp_v); end
         total++; if (rdy[0] !== exp_r) begin bad++; $display("FAIL single_ready e=%0d: got %b want %b", e, rdy[0], exp_r); end
         if (e == 4) begin
            total++; if (dout[0] !== V1_OUT) begin bad++; $display("FAIL single_data: got %h want %h", dout[0], V1_OUT); end
         end
      end
   endtask

   task automatic test_fips();
      logic exp_v;
      int   n;
      do_reset();
      for (int k = 0; k < NI; k++) begin
         n = ncyc(k);
         din[k] = FIPS_IN; vin[k] = 1'b1;
         tick();
         vin[k] = 1'b0;
         for (int e = 1; e <= n + 1; e++) begin
            tick();
            exp_v = (e == n);
            total++; if (vout[k] !== exp_v) begin bad++; $display("FAIL fips_valid[%0d] e=%0d: got %b want %b", k, e, vout[k], exp_v); end
            if (e == n) begin
               total++; if (dout[k] !== FIPS_OUT) begin bad++; $display("FAIL fips_data[%0d]: got %h want %h", k, dout[k], FIPS_OUT); end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rin[0] = 1'b0;
      din[0] = V1_IN; vin[0] = 1'b1;
      tick();
      vin[0] = 1'b0;
      for (int g = 0; g < 10 && !vout[0]; g++) tick();
      total++; if (vout[0] !== 1'b1) begin bad++; $display("FAIL bp_timeout: got valid %b want 1", vout[0]); end
      for (int i = 0; i < 7; i++) begin
         tick();
         total++; if (vout[0] !== 1'b1) begin bad++; $display("FAIL bp_valid i=%0d: got %b want 1", i, vout[0]); end
         total++; if (dout[0] !== V1_OUT) begin bad++; $display("FAIL bp_data i=%0d: got %h want %h", i, dout[0], V1_OUT); end
         total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL bp_ready i=%0d: got %b want 0", i, rdy[0]); end
      end
      rin[0] = 1'b1;
      tick();
      total++; if (vout[0] !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", vout[0]); end
      total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", rdy[0]); end
   endtask

   // A held second request must wait for IDLE; all-ones is a fixed point of InvMixColumns.
   task automatic test_busy_reject();
      do_reset();
      din[0] = V1_IN; vin[0] = 1'b1;
      tick();
      din[0] = '1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         if (e < 4) begin
            total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL br_ready_busy e=%0d: got %b want 0", e, rdy[0]); end
         end else begin
            total++; if (vout[0] !== 1'b1) begin bad++; $display("FAIL br_valid_first: got %b want 1", vout[0]); end
            total++; if (dout[0] !== V1_OUT) begin bad++; $display("FAIL br_data_first: got %h want %h", dout[0], V1_OUT); end
         end
      end
      tick();
      total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL br_ready_idle: got %b want 1", rdy[0]); end
      tick();
      vin[0] = 1'b0;
      total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL br_second_accept: got ready %b want 0", rdy[0]); end
      repeat (4) tick();
      total++; if (vout[0] !== 1'b1) begin bad++; $display("FAIL br_valid_second: got %b want 1", vout[0]); end
      total++; if (dout[0] !== {128{1'b1}}) begin bad++; $display("FAIL br_data_second: got %h want all ones", dout[0]); end
   endtask

   task automatic test_reset_mid_busy();
      logic exp_v;
      do_reset();
      din[0] = V1_IN; vin[0] = 1'b1;
      tick();
      vin[0] = 1'b0;
      repeat (2) tick();
      #2 rst = 1'b1;
      #1;
      total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", rdy[0]); end
      total++; if (vout[0] !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", vout[0]); end
      total++; if (dout[0] !== 128'h0) begin bad++; $display("FAIL rmid_data: got %h want 0", dout[0]); end
      #1 rst = 1'b0;
      tick();
      din[0] = '0; vin[0] = 1'b1;
      tick();
      vin[0] = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         exp_v = (e == 4);
         total++; if (vout[0] !== exp_v) begin bad++; $display("FAIL rmid_after_valid e=%0d: got %b want %b", e, vout[0], exp_v); end
      end
      total++; if (dout[0] !== 128'h0) begin bad++; $display("FAIL rmid_after_data: got %h want 0", dout[0]); end
   endtask

   task automatic test_round_trip();
      logic [127:0] x;
      int n, m, acc, prev, g;
      do_reset();
      for (int k = 0; k < NI; k++) begin
         n = ncyc(k);
         m = (k == 0) ? 1000 : 100;
         prev = 0;
         for (int i = 0; i < m; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            din[k] = mix(x); vin[k] = 1'b1;
            g = 0;
            while (!rdy[k] && g < 20) begin tick(); g++; end
            if (!rdy[k]) begin
               total++; bad++;
               $display("FAIL rt_ready_timeout[%0d] i=%0d: got ready %b want 1", k, i, rdy[k]);
               break;
            end
            tick();
            acc = cyc;
            vin[k] = 1'b0;
            if (i > 0) begin
               total++; if (acc - prev != n + 2) begin bad++; $display("FAIL rt_spacing[%0d] i=%0d: got %0d want %0d", k, i, acc - prev, n + 2); end
            end
            prev = acc;
            g = 0;
            while (!vout[k] && g < 20) begin tick(); g++; end
            total++;
            if (vout[k] !== 1'b1 || dout[k] !== x) begin
               bad++;
               $display("FAIL rt_data[%0d] i=%0d: got v=%b %h want v=1 %h", k, i, vout[k], dout[k], x);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         din[k] = '0; vin[k] = 1'b0; rin[k] = 1'b1;
      end
      test_reset();
      test_single();
      test_fips();
      test_backpressure();
      test_busy_reject();
      test_reset_mid_busy();
      test_round_trip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule
